// File: rtl/wb_stream_pixel_fifo.sv
// Camera pixel packer plus first-word-fall-through word FIFO feeding the Wishbone burst writer.
// Pixel pairs are packed low-half-first. Overflow, underflow and misalign are sticky status flags.
module wb_stream_pixel_fifo #(
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 9
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 enable_i,
  input  logic                 flush_i,
  input  logic                 clr_status_i,
  input  logic [WB_DW/2-1:0]   pix_d_i,
  input  logic                 pix_valid_i,
  input  logic                 pix_sof_i,
  output logic [WB_DW-1:0]     fifo_d,
  input  logic                 fifo_rd,
  output logic [FIFO_AW:0]     fifo_cnt,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 misalign_o
);

  localparam int PW    = WB_DW / 2;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic {EVEN, ODD} phase_t;

  phase_t             state, state_nx;
  logic [PW-1:0]      lo_q;
  logic               pix_ev, lo_ld, push_req, mis_evt;
  logic               empty, full, pop, push_ok, ovf_evt, unf_evt;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [WB_DW-1:0]   mem [DEPTH];

  assign pix_ev = enable_i & pix_valid_i;

  // Packer phase register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i)  state <= EVEN;
    else if (flush_i) state <= EVEN;
    else              state <= state_nx;
  end

  // SOF always restarts the pair, so its pixel lands in the low half
  always_comb begin
    state_nx = state;
    if (!enable_i)        state_nx = EVEN;
    else if (pix_valid_i) state_nx = (pix_sof_i || state == EVEN) ? ODD : EVEN;
  end

  always_comb begin
    lo_ld    = pix_ev & ((state == EVEN) | pix_sof_i);
    push_req = pix_ev & (state == ODD) & ~pix_sof_i;
    mis_evt  = pix_ev & pix_sof_i & (state == ODD);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) lo_q <= '0;
    else if (lo_ld)  lo_q <= pix_d_i;
  end

  assign empty   = (fifo_cnt == '0);
  assign full    = (fifo_cnt == CNT_FULL);
  assign pop     = fifo_rd & ~empty;
  // A full FIFO still takes the word when the head is popped in the same cycle
  assign push_ok = push_req & (~full | fifo_rd);
  assign ovf_evt = push_req & full & ~fifo_rd;
  assign unf_evt = fifo_rd & empty;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n_i && !flush_i && push_ok) mem[wr_ptr] <= {pix_d_i, lo_q};
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Set wins over clear; flush leaves status untouched
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (!flush_i) begin
      overflow_o  <= (overflow_o  & ~clr_status_i) | ovf_evt;
      underflow_o <= (underflow_o & ~clr_status_i) | unf_evt;
      misalign_o  <= (misalign_o  & ~clr_status_i) | mis_evt;
    end
  end

  assign fifo_d = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_wb_stream_pixel_fifo.sv
// Randomised and directed bench for wb_stream_pixel_fifo (DEPTH 4) against a queue-based model.
module tb_wb_stream_pixel_fifo;
  localparam int DW = 32, AW = 2, DEPTH = 4;

  logic clk = 0, rst_n = 0, en = 0, flush = 0, clr = 0, valid = 0, sof = 0, rd = 0;
  logic [DW/2-1:0] pix = '0;
  logic [DW-1:0]   fifo_d;
  logic [AW:0]     fifo_cnt;
  logic            ovf, unf, mis;

  wb_stream_pixel_fifo #(.WB_DW(DW), .FIFO_AW(AW)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .enable_i(en), .flush_i(flush), .clr_status_i(clr),
    .pix_d_i(pix), .pix_valid_i(valid), .pix_sof_i(sof), .fifo_d(fifo_d), .fifo_rd(rd),
    .fifo_cnt(fifo_cnt), .overflow_o(ovf), .underflow_o(unf), .misalign_o(mis));

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;

  // Reference model: a word queue, an optional pending low half, three sticky flags
  logic [DW-1:0]   mq[$];
  logic            pend_v = 0;
  logic [DW/2-1:0] pend_d = '0;
  logic            m_ov = 0, m_un = 0, m_mis = 0;

  task automatic model_step();
    logic e_ov, e_un, e_mis, have_w;
    logic [DW-1:0] w;
    e_ov = 0; e_un = 0; e_mis = 0; have_w = 0; w = '0;
    if (!rst_n) begin
      mq.delete(); pend_v = 0; m_ov = 0; m_un = 0; m_mis = 0;
    end else if (flush) begin
      mq.delete(); pend_v = 0;
    end else begin
      if (!en) pend_v = 0;
      else if (valid) begin
        if (sof) begin
          e_mis = pend_v; pend_d = pix; pend_v = 1;
        end else if (pend_v) begin
          w = {pix, pend_d}; have_w = 1; pend_v = 0;
        end else begin
          pend_d = pix; pend_v = 1;
        end
      end
      if (have_w && mq.size() == DEPTH && !rd) e_ov = 1;
      if (rd && mq.size() == 0) e_un = 1;
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (have_w && !e_ov) mq.push_back(w);
      m_ov  = (m_ov  & ~clr) | e_ov;
      m_un  = (m_un  & ~clr) | e_un;
      m_mis = (m_mis & ~clr) | e_mis;
    end
  endtask

  task automatic drive(input logic r_n, input logic e, input logic f, input logic c,
                       input logic v, input logic s, input logic [DW/2-1:0] d, input logic r);
    rst_n = r_n; en = e; flush = f; clr = c; valid = v; sof = s; pix = d; rd = r;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic px(input logic [DW/2-1:0] d, input logic s = 0, input logic r = 0);
    drive(1, 1, 0, 0, 1, s, d, r);
  endtask

  task automatic idle(input logic f = 0, input logic c = 0, input logic r = 0);
    drive(1, 1, f, c, 0, 0, '0, r);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, '0, 0);
    drive(0, 1, 0, 0, 1, 0, 16'hdead, 1);
    n_chk++; if (fifo_cnt !== 0) $display("FAIL reset_cnt got %0d want 0", fifo_cnt); else n_pass++;
    n_chk++; if (fifo_d !== 0) $display("FAIL reset_d got %h want 0", fifo_d); else n_pass++;
    n_chk++; if ({ovf, unf, mis} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ovf, unf, mis}); else n_pass++;
  endtask

  task automatic test_basic();
    px(16'h1111);
    n_chk++; if (fifo_cnt !== 0) $display("FAIL basic_cnt0 got %0d want 0", fifo_cnt); else n_pass++;
    px(16'h2222);
    n_chk++; if (fifo_cnt !== 1) $display("FAIL basic_cnt1 got %0d want 1", fifo_cnt); else n_pass++;
    px(16'h3333); px(16'h4444);
    n_chk++; if (fifo_cnt !== 2) $display("FAIL basic_cnt2 got %0d want 2", fifo_cnt); else n_pass++;
    n_chk++; if (fifo_d !== 32'h22221111) $display("FAIL basic_head got %h want 22221111", fifo_d); else n_pass++;
    idle(0, 0, 1);
    n_chk++; if (fifo_d !== 32'h44443333) $display("FAIL basic_pop got %h want 44443333", fifo_d); else n_pass++;
    n_chk++; if (fifo_cnt !== 1) $display("FAIL basic_popcnt got %0d want 1", fifo_cnt); else n_pass++;
    idle(1);
  endtask

  task automatic test_overflow();
    idle(0, 1);
    for (int i = 1; i <= 8; i++) px(16'(i * 16'h0101));
    n_chk++; if (fifo_cnt !== 4) $display("FAIL ovf_fill got %0d want 4", fifo_cnt); else n_pass++;
    px(16'h0909); px(16'h0a0a);
    n_chk++; if (fifo_cnt !== 4) $display("FAIL ovf_cnt got %0d want 4", fifo_cnt); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else n_pass++;
    n_chk++; if (fifo_d !== 32'h02020101) $display("FAIL ovf_head got %h want 02020101", fifo_d); else n_pass++;
    idle(0, 1);
    n_chk++; if (ovf !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf); else n_pass++;
    px(16'h0b0b); px(16'h0c0c, 0, 1);
    n_chk++; if (fifo_cnt !== 4 || ovf !== 1'b0) $display("FAIL ovf_rdpush got cnt=%0d ovf=%b want 4/0", fifo_cnt, ovf); else n_pass++;
    n_chk++; if (fifo_d !== 32'h04040303) $display("FAIL ovf_rdhead got %h want 04040303", fifo_d); else n_pass++;
    idle(1);
  endtask

  task automatic test_misalign();
    idle(0, 1);
    px(16'haaaa); px(16'hbbbb); px(16'hcccc); px(16'hdddd, 1); px(16'heeee);
    n_chk++; if (fifo_cnt !== 2) $display("FAIL mis_cnt got %0d want 2", fifo_cnt); else n_pass++;
    n_chk++; if (fifo_d !== 32'hbbbbaaaa) $display("FAIL mis_w0 got %h want bbbbaaaa", fifo_d); else n_pass++;
    n_chk++; if (mis !== 1'b1) $display("FAIL mis_flag got %b want 1", mis); else n_pass++;
    idle(0, 0, 1);
    n_chk++; if (fifo_d !== 32'heeeedddd) $display("FAIL mis_w1 got %h want eeeedddd", fifo_d); else n_pass++;
    idle(0, 1);
    n_chk++; if (mis !== 1'b0) $display("FAIL mis_clr got %b want 0", mis); else n_pass++;
    idle(1);
  endtask

  task automatic test_underflow();
    idle(0, 0, 1);
    n_chk++; if (unf !== 1'b1 || fifo_cnt !== 0) $display("FAIL unf_flag got unf=%b cnt=%0d want 1/0", unf, fifo_cnt); else n_pass++;
    idle(0, 1);
    px(16'h1234); px(16'h5678, 0, 1);
    n_chk++; if (fifo_cnt !== 1 || unf !== 1'b1) $display("FAIL unf_push got cnt=%0d unf=%b want 1/1", fifo_cnt, unf); else n_pass++;
    n_chk++; if (fifo_d !== 32'h56781234) $display("FAIL unf_head got %h want 56781234", fifo_d); else n_pass++;
    idle(1); idle(0, 1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w[$];
    logic [DW/2-1:0] lo;
    logic [DW/2-1:0] d;
    for (int i = 0; i < 2 * DEPTH * 3; i++) begin
      d = 16'($urandom);
      if (i % 2 == 0) lo = d; else exp_w.push_back({d, lo});
      if (i % 2 == 0 && i > 0) begin
        n_chk++; if (fifo_d !== exp_w[0]) $display("FAIL b2b_order got %h want %h", fifo_d, exp_w[0]); else n_pass++;
        void'(exp_w.pop_front());
      end
      px(d, 0, (i % 2 == 0 && i > 0));
    end
    n_chk++; if (fifo_cnt !== 1 || fifo_d !== exp_w[0]) $display("FAIL b2b_tail got cnt=%0d d=%h want 1/%h", fifo_cnt, fifo_d, exp_w[0]); else n_pass++;
    idle(0, 0, 1);
    n_chk++; if ({ovf, unf, mis} !== 3'b000 || fifo_cnt !== 0) $display("FAIL b2b_flags got %b cnt=%0d want 000/0", {ovf, unf, mis}, fifo_cnt); else n_pass++;
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 7; i++) px(16'(16'h7000 + i));
    idle(1);
    n_chk++; if (fifo_cnt !== 0) $display("FAIL flush_cnt got %0d want 0", fifo_cnt); else n_pass++;
    px(16'h0101); px(16'h0202);
    n_chk++; if (fifo_d !== 32'h02020101 || mis !== 1'b0) $display("FAIL flush_w0 got %h mis=%b want 02020101/0", fifo_d, mis); else n_pass++;
    idle(0, 0, 1); idle(0, 0, 1);
    px(16'h0303); px(16'h0404, 1);
    for (int i = 0; i < 7; i++) px(16'(16'h8000 + i));
    n_chk++; if ({unf, mis} !== 2'b11) $display("FAIL pre_reset_flags got %b want 11", {unf, mis}); else n_pass++;
    drive(0, 1, 0, 0, 0, 0, '0, 0);
    n_chk++; if (fifo_cnt !== 0 || {ovf, unf, mis} !== 3'b000) $display("FAIL rst_mid got cnt=%0d flags=%b want 0/000", fifo_cnt, {ovf, unf, mis}); else n_pass++;
    px(16'h0505); px(16'h0606);
    n_chk++; if (fifo_d !== 32'h06060505 || mis !== 1'b0) $display("FAIL rst_w0 got %h mis=%b want 06060505/0", fifo_d, mis); else n_pass++;
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            16'($urandom), ($urandom_range(0, 2) == 0));
      n_chk++; if (fifo_cnt !== mq.size()) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, fifo_cnt, mq.size()); else n_pass++;
      if (mq.size() > 0) begin
        n_chk++; if (fifo_d !== mq[0]) $display("FAIL rnd_head cyc %0d got %h want %h", i, fifo_d, mq[0]); else n_pass++;
      end
      n_chk++; if ({ovf, unf, mis} !== {m_ov, m_un, m_mis}) $display("FAIL rnd_flags cyc %0d got %b want %b", i, {ovf, unf, mis}, {m_ov, m_un, m_mis}); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_misalign();
    test_underflow();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_stream_pixel_fifo.md
Name: wb_stream_pixel_fifo

Overview:
- Upstream neighbour of the Wishbone burst-writer controller in the camera capture path.
- Takes the camera pixel stream (one WB_DW/2-bit pixel per valid cycle, no backpressure) and packs pixel pairs into WB_DW-bit words.
- Buffers the words in a synchronous first-word-fall-through FIFO and presents data/count/read-strobe to the burst writer.
- Flags overflow (camera outran memory) and underflow (reader misbehaved) as sticky status.

Parameters:
WB_DW, 32, word width; pixel width is WB_DW/2.
FIFO_AW, 9, FIFO address width; depth DEPTH = 2**FIFO_AW words.

Ports:
wb_clk_i  in  1  single clock, all logic on rising edge.
wb_rst_n_i  in  1  reset, synchronous, active-low.
enable_i  in  1  capture enable; pixels ignored while 0.
flush_i  in  1  synchronous FIFO/packer clear.
clr_status_i  in  1  clears sticky flags.
pix_d_i  in  WB_DW/2  pixel data.
pix_valid_i  in  1  pixel qualifier; there is no ready.
pix_sof_i  in  1  start of frame, qualified by pix_valid_i.
fifo_d  out  WB_DW  head word, FWFT.
fifo_rd  in  1  pop strobe (the writer's wbm_ack_i).
fifo_cnt  out  FIFO_AW+1  words readable, 0..DEPTH.
overflow_o  out  1  sticky: packed word dropped because FIFO was full.
underflow_o  out  1  sticky: fifo_rd asserted while fifo_cnt==0.
misalign_o  out  1  sticky: SOF arrived with an unpaired half-word pending.

Behaviour:
Reset and clear priority:
- Reset (wb_rst_n_i==0 at edge): fifo_cnt=0, pointers=0, packer phase=0, all flags=0, fifo_d=0.
- Priority: reset > flush_i > normal.
- flush_i: pointers=0, fifo_cnt=0, phase=0; the pending half-word is discarded; flags are unchanged; a same-cycle fifo_rd or push is discarded.
- clr_status_i: clears all three flags. If a flag event occurs in the same cycle, the flag is set (set wins).

Packer (states EVEN/ODD, reset EVEN):
- enable_i==0: the pixel is ignored and phase is forced to EVEN.
- Valid pixel in EVEN: store it as the low half, go to ODD.
- Valid pixel in ODD: push word {pix_d_i, low_half}, go to EVEN.
- First pixel of a frame occupies bits [WB_DW/2-1:0].
- pix_sof_i with a valid pixel: the pixel is always treated as EVEN. If phase was ODD, drop the pending half-word and set misalign_o.

FIFO:
- Push accepted if fifo_cnt<DEPTH, or if fifo_cnt==DEPTH and fifo_rd==1 in the same cycle.
- Otherwise the word is dropped and overflow_o is set; fifo_cnt stays DEPTH.
- Pop occurs only if fifo_rd==1 and fifo_cnt>0. fifo_rd with fifo_cnt==0 sets underflow_o with no state change.
- Push and pop in the same cycle (cnt>0): fifo_cnt unchanged, head advances.
- Push and pop in the same cycle with cnt==0: pop ignored and underflow set, push lands, fifo_cnt=1.

Timing:
- A word pushed on edge N is visible on fifo_d with fifo_cnt incremented after edge N; it is readable in cycle N+1. Latency from second pixel to availability is 1 cycle.
- fifo_d is valid whenever fifo_cnt>0, and must equal the oldest word combinationally in that cycle (the writer samples it with ack).
- After a pop on edge M, the next word is on fifo_d after edge M.
- The FIFO wraps pointers modulo DEPTH. fifo_cnt is exact, including the full value DEPTH (extra MSB).
- Block-RAM implementation with a prefetch/output register is permitted, but fifo_cnt must never exceed the words actually presentable on fifo_d.
- fifo_d is don't-care when fifo_cnt==0.
- Reset mid-frame: the next pixel is EVEN regardless of pix_sof_i.

Test Plan:
- FIFO_AW=2 (DEPTH 4), enable=1: feed pixels 0x1111,0x2222,0x3333,0x4444 -> fifo_cnt 0→1→2; fifo_d=0x22221111; after one fifo_rd, fifo_d=0x44443333 and cnt=1.
- Fill to 4 words, then push a 5th pair without fifo_rd -> 5th word dropped, overflow_o=1, cnt=4, fifo_d unchanged. Repeat with fifo_rd on the push cycle -> accepted, no overflow, cnt=4.
- Pixels A,B,C, then pix_sof_i with D,E -> words {B,A},{E,D}; C discarded, misalign_o=1. clr_status_i -> misalign_o=0 next cycle.
- Pulse fifo_rd at cnt=0 -> underflow_o=1, cnt stays 0. Same-cycle push completing a pair at cnt=0 -> cnt=1.
- Stream 2*DEPTH*3 pixels with fifo_rd every other cycle (matches input rate) -> no flags, words emerge in order across ≥3 pointer wraps.
- Mid-operation: 3 words buffered plus one pending half, assert flush_i -> cnt=0 next cycle; next two pixels form word 0 with no misalign. Repeat with wb_rst_n_i=0 -> all flags cleared.
